// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared encodings for the parking zone controller
package parking_pkg;

  localparam logic CLS_FREE = 1'b0;
  localparam logic CLS_UNI  = 1'b1;

  localparam int HOURS_PER_DAY = 24;

  typedef enum logic {
    GATE_IDLE = 1'b0,
    GATE_OPEN = 1'b1
  } gate_state_t;

endpackage

// File: rtl/parking_tod_sched.sv
// rtl/parking_tod_sched.sv - time-of-day counter and hourly free-capacity schedule
module parking_tod_sched
  import parking_pkg::*;
#(
  parameter int TOTAL_SPACES     = 700,
  parameter int FREE_CAP_MORNING = 200,
  parameter int FREE_CAP_NIGHT   = 500,
  parameter int MORNING_START    = 8,
  parameter int RAMP_START       = 13,
  parameter int NIGHT_START      = 16,
  parameter int RAMP_STEP        = 50,
  parameter int CLOCKS_PER_HOUR  = 100,
  parameter int CNT_W            = $clog2(TOTAL_SPACES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hour_load,
  input  logic [4:0]       hour_in,
  output logic [4:0]       hour,
  output logic [CNT_W-1:0] free_cap
);

  localparam int               CYC_W     = (CLOCKS_PER_HOUR > 1) ? $clog2(CLOCKS_PER_HOUR) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLOCKS_PER_HOUR - 1);
  localparam logic [4:0]       LAST_HOUR = 5'(HOURS_PER_DAY - 1);
  localparam logic [4:0]       MS_H      = 5'(MORNING_START);
  localparam logic [4:0]       RS_H      = 5'(RAMP_START);
  localparam logic [4:0]       NS_H      = 5'(NIGHT_START);

  logic [CYC_W-1:0] r_cyc;
  logic [4:0]       r_hour;
  logic [CNT_W-1:0] r_free_cap;
  logic [CNT_W-1:0] w_free_cap_nxt;
  int               w_ramp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc  <= '0;
      r_hour <= MS_H;
    end else if (hour_load) begin
      r_cyc  <= '0;
      r_hour <= (hour_in > LAST_HOUR) ? 5'd0 : hour_in;
    end else if (r_cyc == CYC_LAST) begin
      r_cyc  <= '0;
      r_hour <= (r_hour == LAST_HOUR) ? 5'd0 : r_hour + 5'd1;
    end else begin
      r_cyc  <= r_cyc + CYC_W'(1);
    end
  end

  // Afternoon ramp climbs one step per hour but never past the night ceiling.
  always_comb begin
    w_ramp = FREE_CAP_MORNING + (int'(r_hour) - RAMP_START + 1) * RAMP_STEP;
    if (w_ramp > FREE_CAP_NIGHT) w_ramp = FREE_CAP_NIGHT;
    w_free_cap_nxt = CNT_W'(FREE_CAP_NIGHT);
    if (r_hour >= MS_H && r_hour < RS_H)
      w_free_cap_nxt = CNT_W'(FREE_CAP_MORNING);
    else if (r_hour >= RS_H && r_hour < NS_H)
      w_free_cap_nxt = CNT_W'(w_ramp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_free_cap <= CNT_W'(FREE_CAP_MORNING);
    else     r_free_cap <= w_free_cap_nxt;
  end

  assign hour     = r_hour;
  assign free_cap = r_free_cap;

endmodule

// File: rtl/parking_zone_ctrl.sv
// rtl/parking_zone_ctrl.sv - two-class parking lot controller with entry/exit barrier FSMs
module parking_zone_ctrl
  import parking_pkg::*;
#(
  parameter int TOTAL_SPACES     = 700,
  parameter int FREE_CAP_MORNING = 200,
  parameter int FREE_CAP_NIGHT   = 500,
  parameter int MORNING_START    = 8,
  parameter int RAMP_START       = 13,
  parameter int NIGHT_START      = 16,
  parameter int RAMP_STEP        = 50,
  parameter int CLOCKS_PER_HOUR  = 100,
  parameter int GATE_CYCLES      = 4,
  parameter int CNT_W            = $clog2(TOTAL_SPACES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hour_load,
  input  logic [4:0]       hour_in,
  input  logic             ent_valid,
  input  logic             ent_class,
  output logic             ent_ready,
  output logic             ent_grant,
  output logic             ent_reject,
  output logic             ent_gate_open,
  input  logic             ex_valid,
  input  logic             ex_class,
  output logic             ex_ready,
  output logic             ex_err,
  output logic             ex_gate_open,
  output logic [4:0]       hour,
  output logic [CNT_W-1:0] uni_parked,
  output logic [CNT_W-1:0] free_parked,
  output logic [CNT_W-1:0] uni_vacant,
  output logic [CNT_W-1:0] free_vacant,
  output logic             uni_avail,
  output logic             free_avail
);

  localparam int               TMR_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W:0]   TOT_X    = (CNT_W + 1)'(TOTAL_SPACES);

  logic [CNT_W-1:0] w_free_cap;
  logic [CNT_W-1:0] w_uni_cap;
  logic [CNT_W-1:0] r_uni_parked;
  logic [CNT_W-1:0] r_free_parked;
  logic [CNT_W:0]   w_used;
  logic [CNT_W:0]   w_tot_left;
  logic [CNT_W:0]   w_uni_room;
  logic [CNT_W:0]   w_free_room;
  logic [CNT_W:0]   w_uni_vac;
  logic [CNT_W:0]   w_free_vac;

  gate_state_t      r_ent_state, w_ent_state_nxt;
  gate_state_t      r_ex_state, w_ex_state_nxt;
  logic [TMR_W-1:0] r_ent_tmr;
  logic [TMR_W-1:0] r_ex_tmr;
  logic             r_ent_grant;
  logic             r_ent_reject;
  logic             r_ex_err;

  logic w_ent_hs, w_ent_ok, w_ex_hs, w_ex_ok;
  logic w_uni_inc, w_free_inc, w_uni_dec, w_free_dec;

  parking_tod_sched #(
    .TOTAL_SPACES    (TOTAL_SPACES),
    .FREE_CAP_MORNING(FREE_CAP_MORNING),
    .FREE_CAP_NIGHT  (FREE_CAP_NIGHT),
    .MORNING_START   (MORNING_START),
    .RAMP_START      (RAMP_START),
    .NIGHT_START     (NIGHT_START),
    .RAMP_STEP       (RAMP_STEP),
    .CLOCKS_PER_HOUR (CLOCKS_PER_HOUR),
    .CNT_W           (CNT_W)
  ) u_tod_sched (
    .clk      (clk),
    .rst      (rst),
    .hour_load(hour_load),
    .hour_in  (hour_in),
    .hour     (hour),
    .free_cap (w_free_cap)
  );

  assign w_uni_cap = CNT_W'(TOTAL_SPACES) - w_free_cap;

  // A shrinking class capacity simply reads as zero room; parked cars are never evicted.
  always_comb begin
    w_used      = {1'b0, r_uni_parked} + {1'b0, r_free_parked};
    w_tot_left  = (w_used >= TOT_X) ? '0 : TOT_X - w_used;
    w_uni_room  = (r_uni_parked >= w_uni_cap) ? '0
                : {1'b0, w_uni_cap} - {1'b0, r_uni_parked};
    w_free_room = (r_free_parked >= w_free_cap) ? '0
                : {1'b0, w_free_cap} - {1'b0, r_free_parked};
    w_uni_vac   = (w_uni_room < w_tot_left) ? w_uni_room : w_tot_left;
    w_free_vac  = (w_free_room < w_tot_left) ? w_free_room : w_tot_left;
  end

  assign uni_vacant  = w_uni_vac[CNT_W-1:0];
  assign free_vacant = w_free_vac[CNT_W-1:0];
  assign uni_avail   = |w_uni_vac;
  assign free_avail  = |w_free_vac;

  assign w_ent_hs   = ent_valid & ent_ready;
  assign w_ent_ok   = (ent_class == CLS_UNI) ? uni_avail : free_avail;
  assign w_ex_hs    = ex_valid & ex_ready;
  assign w_ex_ok    = (ex_class == CLS_UNI) ? (r_uni_parked != '0) : (r_free_parked != '0);
  assign w_uni_inc  = w_ent_hs & w_ent_ok & (ent_class == CLS_UNI);
  assign w_free_inc = w_ent_hs & w_ent_ok & (ent_class == CLS_FREE);
  assign w_uni_dec  = w_ex_hs & w_ex_ok & (ex_class == CLS_UNI);
  assign w_free_dec = w_ex_hs & w_ex_ok & (ex_class == CLS_FREE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ent_state <= GATE_IDLE;
      r_ex_state  <= GATE_IDLE;
      r_ent_tmr   <= '0;
      r_ex_tmr    <= '0;
    end else begin
      r_ent_state <= w_ent_state_nxt;
      r_ex_state  <= w_ex_state_nxt;
      r_ent_tmr   <= (r_ent_state == GATE_OPEN) ? r_ent_tmr + TMR_W'(1) : '0;
      r_ex_tmr    <= (r_ex_state == GATE_OPEN) ? r_ex_tmr + TMR_W'(1) : '0;
    end
  end

  always_comb begin
    w_ent_state_nxt = r_ent_state;
    case (r_ent_state)
      GATE_IDLE: if (w_ent_hs && w_ent_ok) w_ent_state_nxt = GATE_OPEN;
      GATE_OPEN: if (r_ent_tmr == TMR_LAST) w_ent_state_nxt = GATE_IDLE;
    endcase
    w_ex_state_nxt = r_ex_state;
    case (r_ex_state)
      GATE_IDLE: if (w_ex_hs && w_ex_ok) w_ex_state_nxt = GATE_OPEN;
      GATE_OPEN: if (r_ex_tmr == TMR_LAST) w_ex_state_nxt = GATE_IDLE;
    endcase
  end

  always_comb begin
    ent_ready     = (r_ent_state == GATE_IDLE);
    ent_gate_open = (r_ent_state == GATE_OPEN);
    ex_ready      = (r_ex_state == GATE_IDLE);
    ex_gate_open  = (r_ex_state == GATE_OPEN);
  end

  // Entry decides on pre-exit vacancy, so same-class entry and exit in one cycle net to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ent_grant   <= 1'b0;
      r_ent_reject  <= 1'b0;
      r_ex_err      <= 1'b0;
      r_uni_parked  <= '0;
      r_free_parked <= '0;
    end else begin
      r_ent_grant   <= w_ent_hs & w_ent_ok;
      r_ent_reject  <= w_ent_hs & ~w_ent_ok;
      r_ex_err      <= w_ex_hs & ~w_ex_ok;
      r_uni_parked  <= r_uni_parked + CNT_W'(w_uni_inc) - CNT_W'(w_uni_dec);
      r_free_parked <= r_free_parked + CNT_W'(w_free_inc) - CNT_W'(w_free_dec);
    end
  end

  assign ent_grant   = r_ent_grant;
  assign ent_reject  = r_ent_reject;
  assign ex_err      = r_ex_err;
  assign uni_parked  = r_uni_parked;
  assign free_parked = r_free_parked;

endmodule

// File: doc/parking_zone_ctrl.md
Name: parking_zone_ctrl

Overview:
- Synchronous, parametrised parking-lot controller for two space classes: university (class 1) and free (class 0).
- Entry and exit lanes use valid/ready handshakes. Each lane has a barrier-gate FSM.
- An on-block time-of-day counter drives an hourly free-capacity schedule.
- Outputs are per-class occupancy and vacancy for the lot display and gate front-ends.

Parameters:
- TOTAL_SPACES, 700, total physical spaces.
- FREE_CAP_MORNING, 200, free capacity during morning hours.
- FREE_CAP_NIGHT, 500, free capacity outside the day window; also the ramp ceiling.
- MORNING_START, 8, first morning hour.
- RAMP_START, 13, first ramp hour.
- NIGHT_START, 16, first night hour.
- RAMP_STEP, 50, free-capacity increment per ramp hour.
- CLOCKS_PER_HOUR, 100, clk cycles per simulated hour.
- GATE_CYCLES, 4, cycles a barrier stays open after a grant.
- CNT_W, $clog2(TOTAL_SPACES+1), width of all counts.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- hour_load  in  1  load hour_in into hour and clear the cycle counter.
- hour_in  in  5  hour to load (0-23; values >23 load as 0).
- ent_valid  in  1  car waiting at entry.
- ent_class  in  1  1 = university car.
- ent_ready  out  1  entry lane can accept a request.
- ent_grant  out  1  one-cycle pulse: entry accepted.
- ent_reject  out  1  one-cycle pulse: no vacancy for the requested class.
- ent_gate_open  out  1  entry barrier open.
- ex_valid  in  1  car waiting at exit.
- ex_class  in  1  1 = university car.
- ex_ready  out  1  exit lane can accept a request.
- ex_err  out  1  one-cycle pulse: exit requested for a class with zero parked cars.
- ex_gate_open  out  1  exit barrier open.
- hour  out  5  current hour.
- uni_parked  out  CNT_W  university cars parked.
- free_parked  out  CNT_W  free cars parked.
- uni_vacant  out  CNT_W  university spaces available.
- free_vacant  out  CNT_W  free spaces available.
- uni_avail  out  1  uni_vacant != 0.
- free_avail  out  1  free_vacant != 0.

Behaviour:
- Reset values: hour = MORNING_START; cycle counter = 0; counts = 0; both FSMs IDLE; all pulse and gate outputs = 0; ready outputs = 1 immediately after reset release.
- Time of day: the cycle counter wraps at CLOCKS_PER_HOUR-1 and then increments hour; hour 23 wraps to 0. hour_load has priority over the increment.
- Free capacity (free_cap):
  - hour in [MORNING_START, RAMP_START) -> FREE_CAP_MORNING.
  - hour in [RAMP_START, NIGHT_START) -> min(FREE_CAP_MORNING + (hour-RAMP_START+1)*RAMP_STEP, FREE_CAP_NIGHT).
  - Otherwise -> FREE_CAP_NIGHT.
  - free_cap is registered and valid 1 cycle after an hour change.
  - University capacity: uni_cap = TOTAL_SPACES - free_cap.
- Vacancy (combinational from registered counts and free_cap):
  - uni_vacant = 0 if uni_parked >= uni_cap, else min(uni_cap - uni_parked, TOTAL_SPACES - uni_parked - free_parked).
  - free_vacant is symmetric, using free_cap and free_parked.
  - Compute at CNT_W+1 bits; results never go negative.
  - When capacity shrinks below occupancy, vacancy = 0. No eviction; counts are unchanged.
- Entry FSM, IDLE -> OPEN -> IDLE:
  - IDLE: ent_ready = 1. On ent_valid & ent_ready, decide using the selected class's avail at that cycle.
  - Granted: ent_grant pulse the next cycle, count +1 at the same edge, go to OPEN.
  - Rejected: ent_reject pulse the next cycle, stay IDLE.
  - OPEN: ent_ready = 0, ent_gate_open = 1 for exactly GATE_CYCLES cycles, then IDLE.
- Exit FSM has the same structure:
  - Parked count of ex_class > 0: count -1, ex_gate_open for GATE_CYCLES cycles.
  - Parked count = 0: ex_err pulse, stay IDLE.
- Simultaneous entry and exit handshakes in one cycle: both are processed. The entry decision uses pre-exit vacancy. Same class gives net count change 0.
- Counts saturate at TOTAL_SPACES and 0 by construction; the vacancy check guarantees this.
- Reset mid-operation: FSMs abort to IDLE, gates close, counts clear. No pulses are emitted on the reset edge.

Decomposition:
- Package parking_pkg: class encoding (CLS_FREE = 0, CLS_UNI = 1), gate FSM state enum, HOURS_PER_DAY = 24.
- Sub-module parking_tod_sched: cycle counter, hour, hour_load, free_cap register. It is instantiated once; the top instantiates the two lane FSMs inline.

Test Plan:
- Reset, then hold idle 1300 cycles (defaults) -> hour 8->21; free_cap 200, 200, 200, 200, 200, 250, 300, 350, 500 at hours 8-16; uni_vacant = 500 at hour 8.
- 200 free entries at hour 8 -> all granted; free_vacant = 0; 201st -> ent_reject, count stays 200; each grant holds ent_ready low 4 cycles.
- hour_load to 16 with uni_parked = 500 -> uni_cap = 200, uni_vacant = 0, uni entry rejected, uni_parked stays 500.
- Exit with uni_parked = 0 -> ex_err pulse, no gate open, count 0.
- Same-cycle uni entry and uni exit with uni_parked = 10 -> ent_grant, exit gate opens, uni_parked remains 10.
- Assert rst during an OPEN gate -> gate_open = 0, counts 0, hour = 8, ready = 1 after release.
